// File: rtl/rtc_counter.sv
// rtc_counter -- real-time clock with 24-hour binary time, BCD display
// digits, optional 12-hour display mode and an optional alarm.
//
// Optional feature: define RTC_ALARM_EN to compile in the alarm logic.
// Without it the alarm inputs are ignored and alarm is tied low.
//
// Parameters:
//   CLK_HZ  clock cycles per second (>= 2)
//   PRE_W   prescaler width, 2**PRE_W >= CLK_HZ
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   run                            count enable (freezes prescaler and time)
//   hour12                         1 = 12-hour display, 0 = 24-hour display
//   load, load_hrs/min/sec         time load strobe and values
//   hrs, min, sec                  binary 24-hour time
//   hrs/min/sec _tens/_ones, pm    BCD display digits and PM flag
//   sec_tick, day_tick, load_err   registered one-cycle event pulses
//   alarm_load, alarm_hrs/min      alarm time load
//   alarm_ack, alarm               alarm acknowledge and latched flag
module rtc_counter #(
  parameter int CLK_HZ = 100000000,
  parameter int PRE_W  = 27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       hour12,
  input  logic       load,
  input  logic [4:0] load_hrs,
  input  logic [5:0] load_min,
  input  logic [5:0] load_sec,
  output logic [4:0] hrs,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic [3:0] hrs_tens,
  output logic [3:0] hrs_ones,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       pm,
  output logic       sec_tick,
  output logic       day_tick,
  output logic       load_err,
  input  logic       alarm_load,
  input  logic [4:0] alarm_hrs,
  input  logic [5:0] alarm_min,
  input  logic       alarm_ack,
  output logic       alarm
);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_HZ - 1);

  logic [PRE_W-1:0] pre_reg;
  logic             load_ok;
  logic             advance;
  logic [4:0]       hrs_adv;
  logic [5:0]       min_adv;
  logic [5:0]       sec_adv;
  logic             wrap_adv;

  assign load_ok = (load_hrs < 5'd24) && (load_min < 6'd60) && (load_sec < 6'd60);
  // A load always wins over a coincident tick, valid or not.
  assign advance = !load && run && (pre_reg == PRE_LAST);

  // One-second increment with carries.
  always_comb begin
    sec_adv  = sec + 6'd1;
    min_adv  = min;
    hrs_adv  = hrs;
    wrap_adv = 1'b0;
    if (sec == 6'd59) begin
      sec_adv = 6'd0;
      min_adv = min + 6'd1;
      if (min == 6'd59) begin
        min_adv = 6'd0;
        hrs_adv = hrs + 5'd1;
        if (hrs == 5'd23) begin
          hrs_adv  = 5'd0;
          wrap_adv = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_reg  <= '0;
      hrs      <= '0;
      min      <= '0;
      sec      <= '0;
      sec_tick <= 1'b0;
      day_tick <= 1'b0;
      load_err <= 1'b0;
    end else begin
      sec_tick <= 1'b0;
      day_tick <= 1'b0;
      load_err <= 1'b0;
      if (load) begin
        if (load_ok) begin
          hrs     <= load_hrs;
          min     <= load_min;
          sec     <= load_sec;
          pre_reg <= '0;
        end else begin
          load_err <= 1'b1;
        end
      end else if (run) begin
        if (advance) begin
          pre_reg  <= '0;
          hrs      <= hrs_adv;
          min      <= min_adv;
          sec      <= sec_adv;
          sec_tick <= 1'b1;
          day_tick <= wrap_adv;
        end else begin
          pre_reg <= pre_reg + 1'b1;
        end
      end
    end
  end

  // Split a value 0..59 into BCD tens/ones by repeated subtraction.
  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    logic [3:0] t;
    logic [5:0] r;
    t = 4'd0;
    r = v;
    for (int k = 0; k < 5; k++) begin
      if (r >= 6'd10) begin
        r = r - 6'd10;
        t = t + 4'd1;
      end
    end
    return {t, r[3:0]};
  endfunction

  logic [4:0] hrs_disp;

  // 12-hour mode maps 0 -> 12 and 13..23 -> 1..11; pm is the same in both modes.
  always_comb begin
    hrs_disp = hrs;
    if (hour12) begin
      if (hrs == 5'd0)
        hrs_disp = 5'd12;
      else if (hrs > 5'd12)
        hrs_disp = hrs - 5'd12;
    end
  end

  assign pm = (hrs >= 5'd12);
  assign {hrs_tens, hrs_ones} = to_bcd({1'b0, hrs_disp});
  assign {min_tens, min_ones} = to_bcd(min);
  assign {sec_tens, sec_ones} = to_bcd(sec);

`ifdef RTC_ALARM_EN
  logic [4:0] alarm_hrs_reg;
  logic [5:0] alarm_min_reg;
  logic       alarm_reg;
  logic       alarm_hit;

  // Only a second advance can trigger; a load onto the match time cannot.
  assign alarm_hit = advance && (hrs_adv == alarm_hrs_reg) &&
                     (min_adv == alarm_min_reg) && (sec_adv == 6'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alarm_hrs_reg <= '0;
      alarm_min_reg <= '0;
      alarm_reg     <= 1'b0;
    end else begin
      if (alarm_load && (alarm_hrs < 5'd24) && (alarm_min < 6'd60)) begin
        alarm_hrs_reg <= alarm_hrs;
        alarm_min_reg <= alarm_min;
      end
      // A new match beats a coincident acknowledge.
      if (alarm_hit)
        alarm_reg <= 1'b1;
      else if (alarm_ack)
        alarm_reg <= 1'b0;
    end
  end

  assign alarm = alarm_reg;
`else
  logic unused_alarm_inputs;
  assign unused_alarm_inputs = ^{alarm_load, alarm_hrs, alarm_min, alarm_ack};
  assign alarm = 1'b0;
`endif

endmodule

// File: tb/tb_rtc_counter.sv
// Testbench for rtc_counter with CLK_HZ=4. A seconds-of-day model runs
// alongside the DUT and is compared every cycle; directed literal checks
// pin the model to hand-computed values.
module tb_rtc_counter;

  localparam int HZ = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic       hour12 = 1'b0;
  logic       load = 1'b0;
  logic [4:0] load_hrs = '0;
  logic [5:0] load_min = '0;
  logic [5:0] load_sec = '0;
  logic [4:0] hrs;
  logic [5:0] min;
  logic [5:0] sec;
  logic [3:0] hrs_tens, hrs_ones, min_tens, min_ones, sec_tens, sec_ones;
  logic       pm, sec_tick, day_tick, load_err;
  logic       alarm_load = 1'b0;
  logic [4:0] alarm_hrs = '0;
  logic [5:0] alarm_min = '0;
  logic       alarm_ack = 1'b0;
  logic       alarm;

  rtc_counter #(.CLK_HZ(HZ), .PRE_W(3)) dut (
    .clk(clk), .rst(rst), .run(run), .hour12(hour12),
    .load(load), .load_hrs(load_hrs), .load_min(load_min), .load_sec(load_sec),
    .hrs(hrs), .min(min), .sec(sec),
    .hrs_tens(hrs_tens), .hrs_ones(hrs_ones), .min_tens(min_tens),
    .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .pm(pm), .sec_tick(sec_tick), .day_tick(day_tick), .load_err(load_err),
    .alarm_load(alarm_load), .alarm_hrs(alarm_hrs), .alarm_min(alarm_min),
    .alarm_ack(alarm_ack), .alarm(alarm)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_t, m_pre, m_ah, m_am;
  bit m_stick, m_dtick, m_lerr, m_alarm;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_t = 0; m_pre = 0; m_ah = 0; m_am = 0;
      m_stick = 0; m_dtick = 0; m_lerr = 0; m_alarm = 0;
    end else begin
      bit hit;
      hit = 0;
      m_stick = 0; m_dtick = 0; m_lerr = 0;
      if (load) begin
        if (load_hrs < 24 && load_min < 60 && load_sec < 60) begin
          m_t = load_hrs * 3600 + load_min * 60 + load_sec;
          m_pre = 0;
        end else begin
          m_lerr = 1;
        end
      end else if (run) begin
        if (m_pre == HZ - 1) begin
          m_pre = 0;
          m_t = (m_t + 1) % 86400;
          m_stick = 1;
          m_dtick = (m_t == 0);
          hit = (m_t == m_ah * 3600 + m_am * 60);
        end else begin
          m_pre++;
        end
      end
`ifdef RTC_ALARM_EN
      if (hit) m_alarm = 1;
      else if (alarm_ack) m_alarm = 0;
      if (alarm_load && alarm_hrs < 24 && alarm_min < 60) begin
        m_ah = alarm_hrs;
        m_am = alarm_min;
      end
`endif
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (!rst) begin
      int h, mi, s, d;
      h = m_t / 3600;
      mi = (m_t / 60) % 60;
      s = m_t % 60;
      d = hour12 ? ((h % 12 == 0) ? 12 : h % 12) : h;
      chk("hrs", hrs, h);
      chk("min", min, mi);
      chk("sec", sec, s);
      chk("hrs_digits", hrs_tens * 10 + hrs_ones, d);
      chk("hrs_ones_range", hrs_ones < 10, 1);
      chk("min_digits", {min_tens, min_ones}, (mi / 10) * 16 + mi % 10);
      chk("sec_digits", {sec_tens, sec_ones}, (s / 10) * 16 + s % 10);
      chk("pm", pm, h >= 12);
      chk("sec_tick", sec_tick, m_stick);
      chk("day_tick", day_tick, m_dtick);
      chk("load_err", load_err, m_lerr);
      chk("alarm", alarm, m_alarm);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int h, input int m, input int s);
    load = 1'b1;
    load_hrs = 5'(h);
    load_min = 6'(m);
    load_sec = 6'(s);
    step();
    load = 1'b0;
  endtask

  initial begin
    // Reset state
    step(); step();
    chk("rst_hrs", hrs, 0);
    chk("rst_min", min, 0);
    chk("rst_sec", sec, 0);
    chk("rst_ticks", {sec_tick, day_tick, load_err, alarm}, 0);
    chk("rst_digits", {hrs_tens, hrs_ones, min_tens, min_ones, sec_tens, sec_ones}, 0);
    chk("rst_pm", pm, 0);
    hour12 = 1'b1;
    #1;
    chk("rst_h12_tens", hrs_tens, 1);
    chk("rst_h12_ones", hrs_ones, 2);
    hour12 = 1'b0;
    #1;
    rst = 1'b0;
    $display("reset released");

    // First tick four cycles after release
    run = 1'b1;
    step(); step(); step();
    chk("pre_tick_sec", sec, 0);
    chk("pre_tick_stick", sec_tick, 0);
    step();
    chk("first_tick_sec", sec, 1);
    chk("first_tick_stick", sec_tick, 1);
    step();
    chk("tick_pulse_once", sec_tick, 0);
    step(); step(); step();
    chk("second_tick_sec", sec, 2);
    $display("txn: run from reset -> sec=%0d", sec);

    // Midnight wrap
    do_load(23, 59, 58);
    chk("load_hrs", hrs, 23);
    chk("load_sec", sec, 58);
    chk("load_no_tick", sec_tick, 0);
    repeat (4) step();
    chk("wrap_pre_sec", sec, 59);
    repeat (4) step();
    chk("wrap_hrs", hrs, 0);
    chk("wrap_min", min, 0);
    chk("wrap_sec", sec, 0);
    chk("wrap_day_tick", day_tick, 1);
    step();
    chk("day_tick_once", day_tick, 0);
    $display("txn: load 23:59:58, run 8 -> %0d:%0d:%0d", hrs, min, sec);

    // Rejected load
    do_load(24, 10, 0);
    chk("bad_load_err", load_err, 1);
    chk("bad_load_hrs", hrs, 0);
    chk("bad_load_min", min, 0);
    step();
    chk("bad_load_err_once", load_err, 0);
    $display("txn: load 24:10:00 rejected");

    // 12-hour display
    run = 1'b0;
    hour12 = 1'b1;
    do_load(0, 0, 0);
    chk("h12_mid_tens", hrs_tens, 1);
    chk("h12_mid_ones", hrs_ones, 2);
    chk("h12_mid_pm", pm, 0);
    do_load(13, 5, 0);
    chk("h12_pm_tens", hrs_tens, 0);
    chk("h12_pm_ones", hrs_ones, 1);
    chk("h12_pm", pm, 1);
    chk("h12_min_ones", min_ones, 5);
    hour12 = 1'b0;
    #1;
    chk("h24_tens", hrs_tens, 1);
    chk("h24_ones", hrs_ones, 3);
    $display("txn: hour12 display 00:00 and 13:05");

    // Frozen, then load coincident with a tick
    repeat (10) step();
    chk("frozen_hrs", hrs, 13);
    chk("frozen_min", min, 5);
    chk("frozen_sec", sec, 0);
    run = 1'b1;
    step(); step(); step();
    do_load(10, 20, 30);
    chk("coinc_hrs", hrs, 10);
    chk("coinc_min", min, 20);
    chk("coinc_sec", sec, 30);
    chk("coinc_no_tick", sec_tick, 0);
    step();
    chk("coinc_no_tick_after", sec_tick, 0);
    $display("txn: load 10:20:30 over tick");

    // Alarm
    alarm_ack = 1'b1;
    step();
    alarm_ack = 1'b0;
    alarm_load = 1'b1;
    alarm_hrs = 5'd0;
    alarm_min = 6'd1;
    step();
    alarm_load = 1'b0;
    do_load(0, 0, 59);
    repeat (4) step();
    chk("alarm_min", min, 1);
`ifdef RTC_ALARM_EN
    chk("alarm_set", alarm, 1);
    repeat (5) step();
    chk("alarm_held", alarm, 1);
    alarm_ack = 1'b1;
    step();
    alarm_ack = 1'b0;
    chk("alarm_acked", alarm, 0);
    // Loading exactly onto the alarm time must not fire it.
    do_load(0, 1, 0);
    chk("alarm_load_nofire", alarm, 0);
`else
    chk("alarm_disabled", alarm, 0);
`endif
    $display("txn: alarm 00:01 sequence, alarm=%0d", alarm);

    // Free run with run toggling
    for (int i = 0; i < 40; i++) begin
      run = (i % 7) != 3;
      step();
    end
    $display("txn: free run done at %0d:%0d:%0d", hrs, min, sec);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rtc_counter.md
RTC_COUNTER -- requirements
Module: rtc_counter

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100000000, input clock cycles per second (min 2).
REQ-002 SHALL have parameter PRE_W, default 27, prescaler width; SHALL satisfy 2^PRE_W >= CLK_HZ.
REQ-003 SHALL use one clock and an asynchronous, active-high reset: clk  in  1  system clock; rst  in  1  async active-high reset.
REQ-004 SHALL have ports: run  in  1  count enable; hour12  in  1  1 = 12-hour display, 0 = 24-hour.
REQ-005 SHALL have ports: load  in  1  load strobe; load_hrs  in  5  0-23; load_min  in  6  0-59; load_sec  in  6  0-59.
REQ-006 SHALL have ports: hrs  out  5  binary 24h hours; min  out  6  binary minutes; sec  out  6  binary seconds.
REQ-007 SHALL have ports: hrs_tens, hrs_ones, min_tens, min_ones, sec_tens, sec_ones  out  4 each  BCD display digits; pm  out  1  PM flag.
REQ-008 SHALL have ports: sec_tick  out  1  one-cycle pulse per second advance; day_tick  out  1  one-cycle pulse on midnight wrap; load_err  out  1  one-cycle pulse on rejected load.
REQ-009 SHALL have ports: alarm_load  in  1; alarm_hrs  in  5; alarm_min  in  6; alarm_ack  in  1; alarm  out  1  latched alarm flag.

Function
REQ-010 Prescaler SHALL count 0..CLK_HZ-1 only while run=1; run=0 freezes prescaler and time.
REQ-011 At prescaler terminal count with run=1: prescaler to 0, sec_tick=1 next cycle, time advances one second on the same edge.
REQ-012 Advance: sec 59->0 carries min; min 59->0 carries hrs; 23:59:59->00:00:00 and day_tick=1 for one cycle.
REQ-013 load=1 with load_hrs<24, load_min<60, load_sec<60: time takes load values at next edge, prescaler clears to 0, no sec_tick that cycle.
REQ-014 load=1 with any field out of range: time and prescaler unchanged, load_err=1 for exactly one cycle.
REQ-015 load SHALL take priority over a coincident tick; the tick is discarded.
REQ-016 load SHALL be accepted regardless of run.
REQ-017 Internal time SHALL always be 24-hour; hour12 affects only hrs_tens/hrs_ones/pm.
REQ-018 hour12=1: hrs 0->12 AM, 1-11 AM, 12 PM, 13-23 -> 1-11 PM; hour12=0: digits show 00-23, pm = (hrs>=12).
REQ-019 BCD outputs and pm SHALL be combinational from registered time (zero-cycle latency after time update).
REQ-020 sec_tick, day_tick, load_err SHALL be registered, never high more than one consecutive cycle per event.

Reset
REQ-021 rst=1 SHALL asynchronously clear prescaler, hrs, min, sec, sec_tick, day_tick, load_err, alarm, and alarm registers to 0.
REQ-022 After reset: digits 0, pm=0; with hour12=1 hour digits read 1,2.
REQ-023 Reset mid-count SHALL discard partial prescaler count; first tick occurs CLK_HZ cycles after release with run=1.

Configuration
REQ-024 Macro RTC_ALARM_EN SHALL compile in the alarm feature.
REQ-025 With RTC_ALARM_EN: alarm_load=1 stores alarm_hrs/alarm_min (rejected silently if out of range); alarm sets when a second advance results in hrs:min:sec == alarm_hrs:alarm_min:00.
REQ-026 With RTC_ALARM_EN: alarm stays 1 until alarm_ack=1; coincident new match and ack leaves alarm=1; a load landing on the match time SHALL NOT set alarm.
REQ-027 Without RTC_ALARM_EN: alarm ports remain, inputs ignored, alarm tied to 0, no alarm registers.

Verification
REQ-028 CLK_HZ=4, rst then run=1 -> sec_tick every 4 cycles, first 4 cycles after release; sec 0->1->2.
REQ-029 load 23:59:58 then run 8 cycles -> 23:59:59 then 00:00:00 with day_tick=1 once.
REQ-030 load hrs=24 min=10 sec=0 -> load_err one cycle, time unchanged.
REQ-031 hour12=1, load 00:00:00 then 13:05:00 -> digits 12 pm=0, then 01 pm=1.
REQ-032 RTC_ALARM_EN, alarm 00:01, load 00:00:59, 4 cycles -> alarm=1, stays until alarm_ack.
REQ-033 run=0 for 10 cycles then load coincident with tick -> time frozen, then load value wins, no sec_tick.
